// File: rtl/vector_accumulate_if.sv
// Streaming handshake bundle for vector_accumulate: input beats in, one reduced vector out per segment.
// The producer/consumer side uses the master modport and the accumulator uses the slave modport.
interface vector_accumulate_if #(
  parameter int dataWidth = 32,
  parameter int pvadd     = 16,
  parameter int cntWidth  = 16
);
  logic                       mode;
  logic                       inValid;
  logic                       inReady;
  logic                       lastin;
  logic [dataWidth*pvadd-1:0] vectorIn;
  logic                       outValid;
  logic                       outReady;
  logic [dataWidth*pvadd-1:0] vectorOut;
  logic [cntWidth-1:0]        outCount;
  logic                       outSat;

  modport master (
    output mode, inValid, lastin, vectorIn, outReady,
    input  inReady, outValid, vectorOut, outCount, outSat
  );

  modport slave (
    input  mode, inValid, lastin, vectorIn, outReady,
    output inReady, outValid, vectorOut, outCount, outSat
  );
endinterface

// File: rtl/vector_accumulate.sv
// Lane-parallel segment accumulator: reduces lastin-delimited segments by lane-wise sum or max,
// reporting the beat count and whether any lane clamped or wrapped during the segment.
//
// state   | meaning
// S_FIRST | next accepted beat starts a new segment (reset state)
// S_ACCUM | segment in progress, accumulating into acc_q
module vector_accumulate #(
  parameter int dataWidth = 32,
  parameter int pvadd     = 16,
  parameter int accWidth  = 40,
  parameter int cntWidth  = 16,
  parameter int SATURATE  = 1
) (
  input logic             clk,
  input logic             rst,
  vector_accumulate_if.slave bus
);

  typedef enum logic [0:0] {S_FIRST, S_ACCUM} state_t;

  localparam logic [accWidth-1:0]  ACC_MAX = {1'b0, {(accWidth-1){1'b1}}};
  localparam logic [accWidth-1:0]  ACC_MIN = {1'b1, {(accWidth-1){1'b0}}};
  localparam logic [dataWidth-1:0] DAT_MAX = {1'b0, {(dataWidth-1){1'b1}}};
  localparam logic [dataWidth-1:0] DAT_MIN = {1'b1, {(dataWidth-1){1'b0}}};

  state_t                     state_q, state_d;
  logic                       seg_mode_q, seg_mode_d;
  logic [accWidth-1:0]        acc_q [pvadd];
  logic [accWidth-1:0]        acc_d [pvadd];
  logic [cntWidth-1:0]        cnt_q, cnt_d;
  logic                       sat_q, sat_d;
  logic                       out_valid_q, out_valid_d;
  logic [dataWidth*pvadd-1:0] vector_out_q, vector_out_d;
  logic [cntWidth-1:0]        out_count_q, out_count_d;
  logic                       out_sat_q, out_sat_d;

  logic                       in_ready;
  logic                       accept;
  logic                       eff_mode;
  logic [accWidth-1:0]        in_ext  [pvadd];
  logic [accWidth-1:0]        acc_upd [pvadd];
  logic [dataWidth*pvadd-1:0] narrowed;
  logic                       lane_ovf;
  logic                       narrow_ovf;
  logic                       add_ovf;
  logic [accWidth-1:0]        add_res;
  logic                       nar_ovf;
  logic [dataWidth-1:0]       nar_res;

  // Returns {overflow, result}; the add is one bit wider so overflow is a sign-bit disagreement.
  function automatic logic [accWidth:0] add_lane(input logic [accWidth-1:0] a,
                                                 input logic [accWidth-1:0] b);
    logic [accWidth:0]   s;
    logic                ovf;
    logic [accWidth-1:0] r;
    s   = {a[accWidth-1], a} + {b[accWidth-1], b};
    ovf = s[accWidth] ^ s[accWidth-1];
    r   = s[accWidth-1:0];
    if (ovf && (SATURATE != 0)) r = s[accWidth] ? ACC_MIN : ACC_MAX;
    return {ovf, r};
  endfunction

  // A value fits dataWidth when every bit above the data sign bit copies it.
  function automatic logic [dataWidth:0] narrow_lane(input logic [accWidth-1:0] a);
    logic                 fits;
    logic [dataWidth-1:0] r;
    fits = (&a[accWidth-1:dataWidth-1]) | ~(|a[accWidth-1:dataWidth-1]);
    r    = a[dataWidth-1:0];
    if (!fits && (SATURATE != 0)) r = a[accWidth-1] ? DAT_MIN : DAT_MAX;
    return {~fits, r};
  endfunction

  assign in_ready = !rst && (!out_valid_q || bus.outReady);
  assign accept   = bus.inValid && in_ready;

  always_comb begin
    state_d      = state_q;
    seg_mode_d   = seg_mode_q;
    cnt_d        = cnt_q;
    sat_d        = sat_q;
    out_valid_d  = out_valid_q;
    vector_out_d = vector_out_q;
    out_count_d  = out_count_q;
    out_sat_d    = out_sat_q;
    lane_ovf     = 1'b0;
    narrow_ovf   = 1'b0;
    add_ovf      = 1'b0;
    add_res      = '0;
    nar_ovf      = 1'b0;
    nar_res      = '0;
    narrowed     = '0;
    eff_mode     = (state_q == S_FIRST) ? bus.mode : seg_mode_q;

    for (int i = 0; i < pvadd; i++) begin
      in_ext[i] = accWidth'($signed(bus.vectorIn[i*dataWidth +: dataWidth]));
      {add_ovf, add_res} = add_lane(acc_q[i], in_ext[i]);
      if (state_q == S_FIRST) begin
        acc_upd[i] = in_ext[i];
      end else if (eff_mode) begin
        acc_upd[i] = ($signed(acc_q[i]) > $signed(in_ext[i])) ? acc_q[i] : in_ext[i];
      end else begin
        acc_upd[i] = add_res;
        lane_ovf   = lane_ovf | add_ovf;
      end
      {nar_ovf, nar_res} = narrow_lane(acc_upd[i]);
      narrowed[i*dataWidth +: dataWidth] = nar_res;
      narrow_ovf = narrow_ovf | nar_ovf;
      acc_d[i]   = accept ? acc_upd[i] : acc_q[i];
    end

    if (accept) begin
      seg_mode_d = eff_mode;
      if (state_q == S_FIRST) begin
        cnt_d = cntWidth'(1);
        sat_d = lane_ovf;
      end else begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + cntWidth'(1);
        sat_d = sat_q | lane_ovf;
      end
      state_d = S_ACCUM;
      if (bus.lastin) begin
        state_d      = S_FIRST;
        out_valid_d  = 1'b1;
        vector_out_d = narrowed;
        out_count_d  = cnt_d;
        out_sat_d    = sat_d | narrow_ovf;
      end
    end

    // A new result loaded this cycle keeps outValid set even while the old one drains.
    if (!(accept && bus.lastin) && out_valid_q && bus.outReady) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FIRST;
      seg_mode_q   <= 1'b0;
      cnt_q        <= '0;
      sat_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      vector_out_q <= '0;
      out_count_q  <= '0;
      out_sat_q    <= 1'b0;
      for (int i = 0; i < pvadd; i++) acc_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      seg_mode_q   <= seg_mode_d;
      cnt_q        <= cnt_d;
      sat_q        <= sat_d;
      out_valid_q  <= out_valid_d;
      vector_out_q <= vector_out_d;
      out_count_q  <= out_count_d;
      out_sat_q    <= out_sat_d;
      for (int i = 0; i < pvadd; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign bus.inReady   = in_ready;
  assign bus.outValid  = out_valid_q;
  assign bus.vectorOut = vector_out_q;
  assign bus.outCount  = out_count_q;
  assign bus.outSat    = out_sat_q;

endmodule

// File: tb/tb_vector_accumulate.sv
// Directed bench for vector_accumulate with 4 lanes; a clamping and a wrapping instance share stimulus.
module tb_vector_accumulate;

  logic         clk;
  logic         rst;
  logic         mode;
  logic         in_valid;
  logic         lastin;
  logic [127:0] vector_in;
  logic         out_ready;
  int           checks;
  int           errors;

  vector_accumulate_if #(.dataWidth(32), .pvadd(4), .cntWidth(16)) bus_s ();
  vector_accumulate_if #(.dataWidth(32), .pvadd(4), .cntWidth(16)) bus_w ();

  assign bus_s.mode     = mode;
  assign bus_s.inValid  = in_valid;
  assign bus_s.lastin   = lastin;
  assign bus_s.vectorIn = vector_in;
  assign bus_s.outReady = out_ready;
  assign bus_w.mode     = mode;
  assign bus_w.inValid  = in_valid;
  assign bus_w.lastin   = lastin;
  assign bus_w.vectorIn = vector_in;
  assign bus_w.outReady = out_ready;

  vector_accumulate #(.dataWidth(32), .pvadd(4), .accWidth(40), .cntWidth(16), .SATURATE(1))
    dut_sat (.clk(clk), .rst(rst), .bus(bus_s));
  vector_accumulate #(.dataWidth(32), .pvadd(4), .accWidth(40), .cntWidth(16), .SATURATE(0))
    dut_wrap (.clk(clk), .rst(rst), .bus(bus_w));

  always #5 clk = ~clk;

  function automatic logic [127:0] pack4(input int a, input int b, input int c, input int d);
    return {d, c, b, a};
  endfunction

  task automatic drive(input logic v, input logic l, input logic m, input logic [127:0] d);
    in_valid  = v;
    lastin    = l;
    mode      = m;
    vector_in = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus_s.outValid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus_s.outValid); end
    checks++; if (bus_s.inReady !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus_s.inReady); end
    checks++; if (bus_s.vectorOut !== 128'd0) begin errors++; $display("FAIL reset_vector_out: got %h expected 0", bus_s.vectorOut); end
    checks++; if (bus_s.outCount !== 16'd0) begin errors++; $display("FAIL reset_out_count: got %0d expected 0", bus_s.outCount); end
    checks++; if (bus_s.outSat !== 1'b0) begin errors++; $display("FAIL reset_out_sat: got %b expected 0", bus_s.outSat); end
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++; if (bus_s.inReady !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", bus_s.inReady); end
  endtask

  task automatic test_sum();
    drive(1'b1, 1'b0, 1'b0, pack4(1, 2, 3, 4));
    tick();
    checks++; if (bus_s.outValid !== 1'b0) begin errors++; $display("FAIL sum_mid_out_valid: got %b expected 0", bus_s.outValid); end
    drive(1'b1, 1'b0, 1'b0, pack4(10, 20, 30, 40));
    tick();
    drive(1'b1, 1'b1, 1'b0, pack4(-5, -5, -5, -5));
    tick();
    drive(1'b0, 1'b0, 1'b0, 128'd0);
    checks++; if (bus_s.outValid !== 1'b1) begin errors++; $display("FAIL sum_out_valid: got %b expected 1", bus_s.outValid); end
    checks++; if (bus_s.vectorOut !== pack4(6, 17, 28, 39)) begin errors++; $display("FAIL sum_vector: got %h expected %h", bus_s.vectorOut, pack4(6, 17, 28, 39)); end
    checks++; if (bus_s.outCount !== 16'd3) begin errors++; $display("FAIL sum_count: got %0d expected 3", bus_s.outCount); end
    checks++; if (bus_s.outSat !== 1'b0) begin errors++; $display("FAIL sum_sat: got %b expected 0", bus_s.outSat); end
    tick();
    checks++; if (bus_s.outValid !== 1'b0) begin errors++; $display("FAIL sum_consumed: got %b expected 0", bus_s.outValid); end
  endtask

  task automatic test_max();
    drive(1'b1, 1'b0, 1'b1, pack4(-7, 5, 0, 100));
    tick();
    drive(1'b1, 1'b1, 1'b0, pack4(-3, 9, -1, 50));
    tick();
    drive(1'b0, 1'b0, 1'b0, 128'd0);
    checks++; if (bus_s.vectorOut !== pack4(-3, 9, 0, 100)) begin errors++; $display("FAIL max_vector: got %h expected %h", bus_s.vectorOut, pack4(-3, 9, 0, 100)); end
    checks++; if (bus_s.outCount !== 16'd2) begin errors++; $display("FAIL max_count: got %0d expected 2", bus_s.outCount); end
    checks++; if (bus_s.outSat !== 1'b0) begin errors++; $display("FAIL max_sat: got %b expected 0", bus_s.outSat); end
    tick();
  endtask

  task automatic test_saturate();
    drive(1'b1, 1'b0, 1'b0, pack4(32'h7FFFFFFF, 0, 0, 0));
    tick();
    drive(1'b1, 1'b1, 1'b0, pack4(32'h7FFFFFFF, 0, 0, 0));
    tick();
    drive(1'b0, 1'b0, 1'b0, 128'd0);
    checks++; if (bus_s.vectorOut !== pack4(32'h7FFFFFFF, 0, 0, 0)) begin errors++; $display("FAIL sat_clamp_vector: got %h expected %h", bus_s.vectorOut, pack4(32'h7FFFFFFF, 0, 0, 0)); end
    checks++; if (bus_s.outSat !== 1'b1) begin errors++; $display("FAIL sat_clamp_flag: got %b expected 1", bus_s.outSat); end
    checks++; if (bus_w.vectorOut !== pack4(32'hFFFFFFFE, 0, 0, 0)) begin errors++; $display("FAIL sat_wrap_vector: got %h expected %h", bus_w.vectorOut, pack4(32'hFFFFFFFE, 0, 0, 0)); end
    checks++; if (bus_w.outSat !== 1'b1) begin errors++; $display("FAIL sat_wrap_flag: got %b expected 1", bus_w.outSat); end
    checks++; if (bus_w.outCount !== 16'd2) begin errors++; $display("FAIL sat_wrap_count: got %0d expected 2", bus_w.outCount); end
    tick();
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, pack4(11, 11, 11, 11));
    tick();
    drive(1'b1, 1'b1, 1'b0, pack4(22, 22, 22, 22));
    #1;
    checks++; if (bus_s.outValid !== 1'b1) begin errors++; $display("FAIL bp_first_valid: got %b expected 1", bus_s.outValid); end
    checks++; if (bus_s.inReady !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low: got %b expected 0", bus_s.inReady); end
    tick();
    tick();
    checks++; if (bus_s.vectorOut !== pack4(11, 11, 11, 11)) begin errors++; $display("FAIL bp_hold_vector: got %h expected %h", bus_s.vectorOut, pack4(11, 11, 11, 11)); end
    checks++; if (bus_s.outCount !== 16'd1) begin errors++; $display("FAIL bp_hold_count: got %0d expected 1", bus_s.outCount); end
    out_ready = 1'b1;
    #1;
    checks++; if (bus_s.inReady !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", bus_s.inReady); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 128'd0);
    checks++; if (bus_s.outValid !== 1'b1) begin errors++; $display("FAIL bp_second_valid: got %b expected 1", bus_s.outValid); end
    checks++; if (bus_s.vectorOut !== pack4(22, 22, 22, 22)) begin errors++; $display("FAIL bp_second_vector: got %h expected %h", bus_s.vectorOut, pack4(22, 22, 22, 22)); end
    checks++; if (bus_s.outCount !== 16'd1) begin errors++; $display("FAIL bp_second_count: got %0d expected 1", bus_s.outCount); end
    tick();
    checks++; if (bus_s.outValid !== 1'b0) begin errors++; $display("FAIL bp_no_duplicate: got %b expected 0", bus_s.outValid); end
  endtask

  task automatic test_back_to_back();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 1'b1, 1'b0, pack4(k * 3, -k, 0, k));
      tick();
      checks++; if (bus_s.outValid !== 1'b1) begin errors++; $display("FAIL b2b_valid_%0d: got %b expected 1", k, bus_s.outValid); end
      checks++; if (bus_s.vectorOut !== pack4(k * 3, -k, 0, k)) begin errors++; $display("FAIL b2b_vector_%0d: got %h expected %h", k, bus_s.vectorOut, pack4(k * 3, -k, 0, k)); end
      checks++; if (bus_s.outCount !== 16'd1) begin errors++; $display("FAIL b2b_count_%0d: got %0d expected 1", k, bus_s.outCount); end
    end
    drive(1'b0, 1'b0, 1'b0, 128'd0);
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 1'b0, pack4(100, 100, 100, 100));
    tick();
    tick();
    drive(1'b0, 1'b0, 1'b0, 128'd0);
    rst = 1'b1;
    tick();
    checks++; if (bus_s.outValid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b expected 0", bus_s.outValid); end
    checks++; if (bus_s.inReady !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready: got %b expected 0", bus_s.inReady); end
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, pack4(7, 7, 7, 7));
    tick();
    drive(1'b0, 1'b0, 1'b0, 128'd0);
    checks++; if (bus_s.vectorOut !== pack4(7, 7, 7, 7)) begin errors++; $display("FAIL rstmid_vector: got %h expected %h", bus_s.vectorOut, pack4(7, 7, 7, 7)); end
    checks++; if (bus_s.outCount !== 16'd1) begin errors++; $display("FAIL rstmid_count: got %0d expected 1", bus_s.outCount); end
    tick();
  endtask

  initial begin
    clk       = 1'b0;
    rst       = 1'b1;
    out_ready = 1'b0;
    checks    = 0;
    errors    = 0;
    drive(1'b0, 1'b0, 1'b0, 128'd0);
    test_reset();
    test_sum();
    test_max();
    test_saturate();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_accumulate.md
# vector_accumulate

Parametrised lane-parallel streaming vector accumulator for the aggregation stage of the GCN datapath. It reduces a segment of `pvadd`-lane vectors, delimited by `lastin`, into one output vector per segment. Supported reductions are lane-wise sum or lane-wise max, in signed fixed point. It adds valid/ready handshaking on both sides, a per-segment beat count (so downstream can form a mean) and saturation reporting. It replaces the free-running, always-valid accumulator lanes of the previous generation.

## Interface
Parameters:
- `dataWidth`, 32, lane width of input and output, signed two's complement
- `pvadd`, 16, number of lanes
- `accWidth`, 40, internal accumulator width per lane; must be ≥ `dataWidth`
- `cntWidth`, 16, width of the beat counter
- `SATURATE`, 1, selects overflow handling: 1 = clamp, 0 = wrap/truncate

Ports:
- `clk`  in  1  sole clock; all logic is on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `mode`  in  1  reduction select: 0 = sum, 1 = max; sampled on the first beat of a segment
- `inValid`  in  1  input beat valid
- `inReady`  out  1  block can accept a beat
- `lastin`  in  1  accepted beat is the final beat of its segment
- `vectorIn`  in  `dataWidth*pvadd`  input lanes; lane i is at bits `[(i+1)*dataWidth-1 : i*dataWidth]`
- `outValid`  out  1  result register holds a segment result
- `outReady`  in  1  downstream accepts the result
- `vectorOut`  out  `dataWidth*pvadd`  result lanes, same lane packing as `vectorIn`
- `outCount`  out  `cntWidth`  number of beats in the segment
- `outSat`  out  1  at least one lane saturated or wrapped during the segment

## Operation
- A beat is accepted when `inValid && inReady`. `inReady = !rst && (!outValid || outReady)`.
- FSM states:
  - FIRST (reset state): next accepted beat starts a segment.
  - ACCUM: segment in progress.
- FIRST, on accept:
  - each `acc[i]` loads the sign-extended `vectorIn[i]`
  - the captured mode `segMode` loads `mode`
  - `cnt` loads 1 and the sticky saturation flag `sat` is cleared
  - if `lastin` = 0, go to ACCUM
- ACCUM, on accept:
  - sum mode: `acc[i] += sext(vectorIn[i])`
  - max mode: `acc[i] = max_signed(acc[i], vectorIn[i])`
  - `cnt` increments, saturating at all-ones
- Accepted beat with `lastin` = 1, in either state:
  - the updated lane values are narrowed to `dataWidth` and written to `vectorOut`, together with the updated `cnt` and `sat`
  - `outValid` sets and the FSM returns to FIRST
- Overflow handling:
  - `SATURATE` = 1: the accumulator add clamps to the `accWidth` signed range, and narrowing clamps to the `dataWidth` signed range.
  - `SATURATE` = 0: both the add and the narrowing wrap (truncation).
  - In either setting, any clamp or wrap in any lane sets `sat` for that segment.
- `mode` changes in mid-segment are ignored.
- Output register:
  - holds its value while `outValid && !outReady`
  - `outValid` clears on `outValid && outReady`, unless a new last beat is accepted in the same cycle, in which case the new result is loaded and `outValid` stays 1
- A segment in progress (ACCUM) keeps accumulating while the output register is full, provided `inReady` is 1; only a stalled output blocks input.

## Timing
- Reset values:
  - `outValid` = 0 and `inReady` = 0 while `rst` is high
  - `vectorOut` = 0, `outCount` = 0, `outSat` = 0
  - FSM in FIRST; all `acc`, `cnt`, `sat` = 0
- Reset in mid-segment discards the partial accumulation. The first beat after reset starts a new segment.
- Throughput: one beat per cycle with no bubbles when `outReady` is held high.
- Latency: the last beat accepted at edge N gives `outValid` = 1 after edge N, i.e. in cycle N+1.
- Single-beat segment (`lastin` on the FIRST beat): `vectorOut` = that input, narrowed; `outCount` = 1.
- Back-pressure: with `outValid` = 1 and `outReady` = 0, `inReady` = 0 in the same cycle (combinational).
- The output fields `vectorOut`, `outCount` and `outSat` are registered and stable while `outValid && !outReady`.

## Test plan
- Sum, 3 beats (`pvadd` = 4): lanes {1,2,3,4}, {10,20,30,40}, {−5,−5,−5,−5} with `lastin` on the third beat -> one cycle later `outValid` = 1, lanes {6,17,28,39}, `outCount` = 3, `outSat` = 0.
- Max mode, 2 beats: {−7,5,0,100} then {−3,9,−1,50} -> {−3,9,0,100}, `outCount` = 2. Toggling `mode` to 0 on the second beat changes nothing.
- Saturation: `SATURATE` = 1, two beats of 0x7FFFFFFF in lane 0 -> lane 0 = 0x7FFFFFFF, `outSat` = 1. With `SATURATE` = 0, the same stimulus gives lane 0 = 0xFFFFFFFE, `outSat` = 1.
- Back-pressure: hold `outReady` = 0 after a result, then present the next segment -> `inReady` = 0 and the result holds unchanged. Release `outReady` -> the result is consumed that cycle, `inReady` = 1, and no beat is lost or duplicated.
- Back-to-back single-beat segments, `outReady` = 1, four beats all with `lastin` = 1 -> four results on consecutive cycles, each with `outCount` = 1.
- Reset mid-segment: two beats of 100 accepted, assert `rst` for one cycle, then send one beat of 7 with `lastin` -> result lane = 7, `outCount` = 1. During the reset cycle `outValid` = 0 and `inReady` = 0.
